// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-based debounce and multi-key detection.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   row        row sense lines, active-low, asynchronous to clk
//   col_sel    column drive, active-low one-hot
//   key_code   last accepted key {col_idx, row_idx}
//   key_valid  one-cycle pulse on key acceptance
//   key_held   high while the accepted key stays pressed
//   multi_key  one-cycle pulse for each frame with two or more pressed keys
module keypad_scanner #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
    logic [3:0] row_m_q, row_s_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0] col_q, col_d;
    logic [1:0] cnt_q, cnt_d, cnt_new;
    logic [3:0] fkey_q, fkey_d, key_new;
    state_t state_q, state_d;
    logic [3:0] cand_q, cand_d, stable_q, stable_d, rel_q, rel_d;
    logic [3:0] key_code_q, key_code_d;
    logic key_valid_q, key_valid_d, key_held_q, key_held_d, multi_q, multi_d;
    logic sample, frame_end, single, multi;
    logic [3:0] pressed, stable_inc, rel_inc;
    logic [2:0] n_col, cnt_sum;
    logic [1:0] r_idx;
    assign sample    = dwell_q == DW'(SCAN_DIV - 1);
    assign frame_end = sample && col_q == 2'd3;
    assign pressed   = ~row_s_q;
    assign n_col     = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
    assign r_idx     = pressed[0] ? 2'd0 : pressed[1] ? 2'd1 : pressed[2] ? 2'd2 : 2'd3;
    // Running per-frame count including the column being sampled now, saturated at 2.
    assign cnt_sum   = {1'b0, cnt_q} + (n_col > 3'd2 ? 3'd2 : n_col);
    assign cnt_new   = cnt_sum >= 3'd2 ? 2'd2 : cnt_sum[1:0];
    assign key_new   = (cnt_q == 2'd0 && n_col != 3'd0) ? {col_q, r_idx} : fkey_q;
    assign single    = cnt_new == 2'd1;
    assign multi     = cnt_new == 2'd2;
    assign stable_inc = (single && key_new == cand_q) ? stable_q + 4'd1 : 4'd1;
    assign rel_inc   = rel_q + 4'd1;
    assign col_sel   = ~(4'b0001 << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_key = multi_q;
    always_comb begin
        dwell_d = sample ? '0 : dwell_q + DW'(1);
        col_d   = sample ? col_q + 2'd1 : col_q;
        cnt_d   = sample ? (frame_end ? 2'd0 : cnt_new) : cnt_q;
        fkey_d  = sample ? (frame_end ? 4'd0 : key_new) : fkey_q;
    end
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        stable_d    = stable_q;
        rel_d       = rel_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        multi_d     = frame_end && multi;
        if (frame_end) begin
            case (state_q)
                IDLE: if (single) begin
                    cand_d   = key_new;
                    stable_d = 4'd1;
                    state_d  = DEBOUNCE;
                    if (DF == 4'd1) begin
                        key_code_d  = key_new;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        stable_d    = 4'd0;
                        state_d     = HELD;
                    end
                end
                DEBOUNCE: if (!single) begin
                    stable_d = 4'd0;
                    state_d  = IDLE;
                end else begin
                    cand_d   = key_new;
                    stable_d = stable_inc;
                    if (stable_inc == DF) begin
                        key_code_d  = key_new;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        stable_d    = 4'd0;
                        state_d     = HELD;
                    end
                end
                HELD: if (!(single && key_new == key_code_q)) begin
                    rel_d   = 4'd1;
                    state_d = RELEASE;
                    if (DF == 4'd1) begin
                        rel_d      = 4'd0;
                        key_held_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                RELEASE: if (single && key_new == key_code_q) begin
                    rel_d   = 4'd0;
                    state_d = HELD;
                end else begin
                    rel_d = rel_inc;
                    if (rel_inc == DF) begin
                        rel_d      = 4'd0;
                        key_held_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m_q     <= 4'hF;
            row_s_q     <= 4'hF;
            dwell_q     <= '0;
            col_q       <= 2'd0;
            cnt_q       <= 2'd0;
            fkey_q      <= 4'd0;
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            stable_q    <= 4'd0;
            rel_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            row_m_q     <= row;
            row_s_q     <= row_m_q;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            fkey_q      <= fkey_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            rel_q       <= rel_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_q     <= multi_d;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random frames against a frame-history reference model.
module tb_keypad_scanner;
    localparam int DF = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] row, col_sel, key_code;
    logic key_valid, key_held, multi_key;
    logic [15:0] mask = '0;
    int n_chk = 0;
    int n_fail = 0;
    int hist[$];
    int idle_since = -1;
    bit m_held = 1'b0;
    logic [3:0] m_code = 4'd0;
    bit pv = 1'b0;
    bit pm = 1'b0;
    always #5 clk = ~clk;
    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(DF)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col_sel(col_sel),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
    );
    // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
    function automatic logic [3:0] keypad(input logic [15:0] m, input logic [3:0] cs);
        logic [3:0] rv;
        rv = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!cs[c] && m[c*4+r]) rv[r] = 1'b0;
        return rv;
    endfunction
    assign row = keypad(mask, col_sel);
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic cyc_chk(input int i);
        logic [3:0] e;
        e = 4'b0001 << (i / 4);
        chk("col_sel", col_sel, ~e);
        chk("key_valid", {3'b0, key_valid}, {3'b0, (i == 0) ? pv : 1'b0});
        chk("multi_key", {3'b0, multi_key}, {3'b0, (i == 0) ? pm : 1'b0});
        chk("key_held", {3'b0, key_held}, {3'b0, m_held});
        chk("key_code", key_code, m_code);
        @(posedge clk);
        #1;
    endtask
    task automatic model(input logic [15:0] m);
        int n, r, f;
        bit all_k, none_c;
        n = $countones(m);
        r = -1;
        for (int b = 0; b < 16; b++) if (m[b]) r = b;
        if (n > 1) r = -2;
        hist.push_back(r);
        f = hist.size() - 1;
        pm = n > 1;
        pv = 1'b0;
        if (!m_held) begin
            all_k = (r >= 0) && (f - idle_since >= DF);
            if (all_k) for (int j = 0; j < DF; j++) if (hist[f-j] != r) all_k = 1'b0;
            if (all_k) begin
                m_held = 1'b1;
                m_code = 4'(r);
                pv = 1'b1;
            end
        end else begin
            none_c = 1'b1;
            for (int j = 0; j < DF; j++) if (hist[f-j] == int'(m_code)) none_c = 1'b0;
            if (none_c) begin
                m_held = 1'b0;
                idle_since = f;
            end
        end
    endtask
    task automatic frame(input logic [15:0] m);
        mask = m;
        for (int i = 0; i < 16; i++) cyc_chk(i);
        model(m);
    endtask
    task automatic partial(input logic [15:0] m, input int n);
        mask = m;
        for (int i = 0; i < n; i++) cyc_chk(i);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst col_sel", col_sel, 4'b1110);
        chk("rst key_code", key_code, 4'd0);
        chk("rst pulses", {1'b0, key_valid, key_held, multi_key}, 4'd0);
        mask = '0;
        hist.delete();
        idle_since = -1;
        m_held = 1'b0;
        m_code = 4'd0;
        pv = 1'b0;
        pm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst hold col_sel", col_sel, 4'b1110);
        chk("rst hold outs", {key_code[3:1], key_valid | key_held | multi_key | key_code[0]}, 4'd0);
        rst_n = 1'b1;
    endtask
    initial begin
        logic [15:0] one, m;
        int a, b;
        one = 16'h0001;
        #12;
        do_reset();
        repeat (2) frame(16'h0000);
        repeat (3) frame(one << 9);
        repeat (3) frame(16'h0000);
        repeat (3) frame(one << 9);
        repeat (2) frame(16'h0000);
        repeat (3) begin
            frame(one << 6);
            frame(16'h0000);
        end
        repeat (3) frame((one << 0) | (one << 15));
        frame(16'h0000);
        frame(one << 9);
        partial(one << 9, 6);
        do_reset();
        frame(one << 9);
        frame(one << 9);
        frame(16'h0000);
        frame(16'h0000);
        m = '0;
        repeat (80) begin
            if ($urandom_range(9) >= 6) begin
                case ($urandom_range(3))
                    0: m = '0;
                    1, 2: m = one << $urandom_range(15);
                    default: begin
                        a = $urandom_range(15);
                        b = (a + 1 + $urandom_range(14)) % 16;
                        m = (one << a) | (one << b);
                    end
                endcase
            end
            frame(m);
        end
        repeat (3) frame(16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles each column is driven; legal range >= 4.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, consecutive identical scan frames needed to accept a press or a release; legal range 1..15.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port row  input  4  keypad row sense lines, active-low (pulled up), asynchronous to clk.
REQ-006 SHALL have port col_sel  output  4  column drive, active-low one-hot.
REQ-007 SHALL have port key_code  output  4  code of the last accepted key, {col_idx[1:0], row_idx[1:0]}.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_held  output  1  high while the accepted key remains pressed.
REQ-010 SHALL have port multi_key  output  1  one-cycle pulse when a frame sees more than one pressed key.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer before any use.
REQ-012 SHALL cycle col_sel 1110 -> 1101 -> 1011 -> 0111 -> 1110, col_idx 0..3, each value held exactly SCAN_DIV cycles via a dwell counter 0..SCAN_DIV-1.
REQ-013 SHALL sample the synchronized row only on the cycle where dwell counter = SCAN_DIV-1; a low bit at row index r marks key {col_idx, r} pressed.
REQ-014 SHALL define a frame as four column dwells; the frame ends on the sample cycle of col_idx 3, and per-frame results are evaluated on that cycle.
REQ-015 SHALL count pressed keys per frame with saturation at 2; a frame result is NONE (0), SINGLE(k) (1), or MULTI (>= 2).
REQ-016 SHALL implement states IDLE, DEBOUNCE, HELD, RELEASE; all transitions occur at frame end; pulse outputs are registered, asserted the cycle after frame end, and low otherwise.
REQ-017 IDLE: SINGLE(k) -> DEBOUNCE with candidate = k and stable count = 1; NONE or MULTI -> stay IDLE.
REQ-018 DEBOUNCE: SINGLE(same candidate) -> increment stable count; SINGLE(different k) -> candidate = k, count = 1; NONE or MULTI -> IDLE, count = 0.
REQ-019 When the stable count reaches DEBOUNCE_FRAMES, SHALL load key_code = candidate, pulse key_valid, set key_held, and enter HELD; with DEBOUNCE_FRAMES = 1 this happens directly from IDLE on the first SINGLE frame.
REQ-020 HELD: SINGLE(key_code) -> stay HELD; any other result -> RELEASE with release count = 1.
REQ-021 RELEASE: SINGLE(key_code) -> HELD with release count = 0; any other result -> increment release count; when it reaches DEBOUNCE_FRAMES, clear key_held and enter IDLE.
REQ-022 SHALL not report a new key before IDLE is re-entered, and SHALL hold key_code until the next accepted key.
REQ-023 SHALL pulse multi_key for every MULTI frame in any state; MULTI never produces key_valid.
REQ-024 SHALL never assert key_valid on two consecutive cycles.

Reset
REQ-025 While rst_n = 0, SHALL force col_sel = 1110, key_code = 0, key_valid = 0, key_held = 0, multi_key = 0, state IDLE, and all counters and synchronizer flops to 0 (row synchronizer flops to 1111).
REQ-026 SHALL restart at the col 0 dwell with dwell count 0 on the first clk edge after rst_n rises; reset mid-frame SHALL discard any partial frame and debounce progress.

Verification (SCAN_DIV = 4, DEBOUNCE_FRAMES = 2)
REQ-027 Release reset, row = 1111 -> col_sel steps 1110, 1101, 1011, 0111 every 4 cycles and repeats; all other outputs stay 0.
REQ-028 Hold row[1] low only while col_sel = 1011 for 3 frames -> a single key_valid pulse with key_code = 1001 after the end of the 2nd frame; key_held = 1 from that cycle.
REQ-029 With the key held, release it -> key_held drops one cycle after the end of the 2nd empty frame; press again -> a second key_valid with key_code = 1001.
REQ-030 Press key 0110 in alternate frames only -> no key_valid, key_held stays 0.
REQ-031 Press keys 0000 and 1111 together -> multi_key pulses once per frame; key_valid never asserts.
REQ-032 Assert rst_n = 0 mid-debounce while col_sel = 1101 -> col_sel = 1110 and all outputs 0 immediately; after reset the press needs 2 full frames again.
